param_vending_machine: RTL and testbench
========================================

PARAM_VENDING_MACHINE -- requirements
Module: param_vending_machine

Interface
REQ-001 Parameter N_ITEMS, default 4, SHALL set the number of products (1..8).
REQ-002 Parameter CREDIT_W, default 6, SHALL set the width of credit, price, coin and change values.
REQ-003 Parameter MAX_CREDIT, default 32, SHALL set the credit ceiling and must be below 2**CREDIT_W.
REQ-004 Parameter ITEM_PRICE, default {4,3,3,2} (item3..item0, CREDIT_W bits each), SHALL set the packed per-item prices, each nonzero.
REQ-005 Parameter DISPENSE_CYC, default 3, SHALL set the number of cycles Dispense is held per sale (>=1).
REQ-006 Parameter TIMEOUT_CYC, default 4, SHALL set the idle-cycle limit before an automatic refund.
REQ-007 Parameter STOCK_W / STOCK_INIT, default 4 / 3, SHALL set the per-item stock counter width and reset value.
REQ-008 Ports SHALL be: Clock in 1, single clock, rising edge; nReset in 1, asynchronous, active-low.
REQ-009 Coin_In in 1 SHALL mark a coin this cycle; Coin_Amt in CREDIT_W SHALL give its value.
REQ-010 Req_Change in 1 SHALL request a refund; Select in N_ITEMS SHALL carry product requests, lowest set index winning.
REQ-011 Outputs SHALL be:
- Credit, out, CREDIT_W
- Change, out, CREDIT_W: remaining refund
- Change_Pulse, out, 1: one unit paid this cycle
- Dispense, out, N_ITEMS: one-hot
- Busy, out, 1
- Coin_Reject, out, 1
- Sold_Out, out, N_ITEMS
All outputs SHALL be registered.

Function
REQ-012 The FSM SHALL have exactly three states, IDLE, DISPENSE and GIVE_CH; Busy SHALL be 1 whenever the state is not IDLE.
REQ-013 In IDLE, the first true condition SHALL apply: (a) winning Select item has Credit >= price and stock nonzero -> DISPENSE, Credit -= price, item latched; (b) (Req_Change or timeout) with Credit != 0 -> GIVE_CH, Change <= Credit, Credit <= 0; (c) otherwise stay.
REQ-014 A coin in IDLE with no transition taken and Credit+Coin_Amt <= MAX_CREDIT SHALL add to Credit next cycle.
REQ-015 Any other coin (over ceiling, same cycle as a transition, or in DISPENSE/GIVE_CH) SHALL be discarded and Coin_Reject pulsed for 1 cycle.
REQ-016 A Select with insufficient credit or zero stock SHALL be ignored: no state, Credit or timer change.
REQ-017 In DISPENSE, Dispense SHALL hold the latched one-hot for exactly DISPENSE_CYC cycles starting the cycle after the transition, then return to IDLE with Dispense = 0.
REQ-018 In GIVE_CH, each cycle SHALL assert Change_Pulse and decrement Change by 1; on the cycle Change goes 1->0, the FSM SHALL return to IDLE.
REQ-019 The timeout counter SHALL reload TIMEOUT_CYC on accepted coin, on entry to IDLE, and while Credit == 0, and SHALL decrement each other IDLE cycle; at 0 with Credit != 0 it SHALL raise timeout, handled as Req_Change.
REQ-020 Credit SHALL never exceed MAX_CREDIT nor underflow; Change never wraps.

Reset
REQ-021 nReset low SHALL, immediately and at any point including mid-dispense or mid-refund, force IDLE; Credit, Change, Change_Pulse, Dispense, Busy and Coin_Reject to 0; timer to TIMEOUT_CYC; all stock to STOCK_INIT; unpaid change is lost.

Configuration
REQ-022 With VEND_STOCK_EN defined, each sale SHALL decrement its item's stock, and Sold_Out[i] SHALL be 1 when stock[i] == 0.
REQ-023 Without VEND_STOCK_EN, no stock counters SHALL exist, stock SHALL be treated as always nonzero, and Sold_Out SHALL be tied to 0.

Verification
REQ-024 Coins 2,2 then Select=0001 -> Credit 4->2, Dispense=0001 for 3 cycles, Busy for 3 cycles, then IDLE.
REQ-025 Credit 5 then Req_Change -> Change 5,4,3,2,1,0 with Change_Pulse for 5 cycles; Credit 0.
REQ-026 Credit 30, coin 5 -> Coin_Reject for 1 cycle, Credit stays 30; coin during DISPENSE -> rejected.
REQ-027 Credit 3, idle with no input -> after 4 cycles, refund of 3 starts automatically; at Credit 0, no refund.
REQ-028 VEND_STOCK_EN: 3 sales of item1 -> Sold_Out[1]=1, 4th Select ignored; nReset pulse mid-refund -> all outputs 0 and stock restored to 3.

Source files
------------

// File: rtl/param_vending_machine.sv
// Parameterised vending machine: coin credit with ceiling, lowest-index product select,
// timed dispense, unit-by-unit change return and an idle timeout that forces a refund.
// Optional per-item stock tracking is enabled by defining VEND_STOCK_EN.
module param_vending_machine #(
  parameter int unsigned N_ITEMS      = 4,
  parameter int unsigned CREDIT_W     = 6,
  parameter int unsigned MAX_CREDIT   = 32,
  parameter logic [N_ITEMS*CREDIT_W-1:0] ITEM_PRICE =
    {CREDIT_W'(4), CREDIT_W'(3), CREDIT_W'(3), CREDIT_W'(2)},
  parameter int unsigned DISPENSE_CYC = 3,
  parameter int unsigned TIMEOUT_CYC  = 4,
  parameter int unsigned STOCK_W      = 4,
  parameter int unsigned STOCK_INIT   = 3
) (
  input  logic                Clock,
  input  logic                nReset,
  input  logic                Coin_In,
  input  logic [CREDIT_W-1:0] Coin_Amt,
  input  logic                Req_Change,
  input  logic [N_ITEMS-1:0]  Select,
  output logic [CREDIT_W-1:0] Credit,
  output logic [CREDIT_W-1:0] Change,
  output logic                Change_Pulse,
  output logic [N_ITEMS-1:0]  Dispense,
  output logic                Busy,
  output logic                Coin_Reject,
  output logic [N_ITEMS-1:0]  Sold_Out
);

  localparam int unsigned IDX_W  = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;
  localparam int unsigned TMR_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam int unsigned DCNT_W = (DISPENSE_CYC > 1) ? $clog2(DISPENSE_CYC) : 1;

  typedef enum logic [1:0] {StIdle, StDispense, StGiveCh} state_e;

  state_e              state_q, state_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
  logic [CREDIT_W-1:0] credit_d, change_d;
  logic [N_ITEMS-1:0]  dispense_d;
  logic                pulse_d, reject_d;

  logic [IDX_W-1:0]    sel_idx;
  logic [N_ITEMS-1:0]  sel_onehot;
  logic [CREDIT_W-1:0] price_sel;
  logic                stock_ok, sell, refund, coin_fits, coin_ok, timeout;

  // Select priority: lowest set index wins
  always_comb begin
    sel_idx = '0;
    for (int i = int'(N_ITEMS) - 1; i >= 0; i--) begin
      if (Select[i]) sel_idx = IDX_W'(i);
    end
  end

  assign sel_onehot = Select & (~Select + N_ITEMS'(1));
  assign price_sel  = ITEM_PRICE[CREDIT_W*sel_idx +: CREDIT_W];
  assign timeout    = (timer_q == '0) && (Credit != '0);
  assign sell       = (state_q == StIdle) && (|Select) && (Credit >= price_sel) && stock_ok;
  assign refund     = (state_q == StIdle) && !sell && (Req_Change || timeout) &&
                      (Credit != '0);
  // Extra bit so the ceiling test cannot be fooled by wrap-around
  assign coin_fits  = ({1'b0, Credit} + {1'b0, Coin_Amt}) <= (CREDIT_W + 1)'(MAX_CREDIT);
  assign coin_ok    = Coin_In && (state_q == StIdle) && !sell && !refund && coin_fits;

`ifdef VEND_STOCK_EN
  logic [STOCK_W-1:0] stock_q [N_ITEMS];

  assign stock_ok = (stock_q[sel_idx] != '0);

  // Per-item stock counters, decremented by each sale; sold-out flags follow them
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < int'(N_ITEMS); i++) stock_q[i] <= STOCK_W'(STOCK_INIT);
      Sold_Out <= (STOCK_INIT == 0) ? '1 : '0;
    end else if (sell) begin
      for (int i = 0; i < int'(N_ITEMS); i++) begin
        if (sel_onehot[i]) begin
          stock_q[i]  <= stock_q[i] - STOCK_W'(1);
          Sold_Out[i] <= (stock_q[i] == STOCK_W'(1));
        end
      end
    end
  end
`else
  assign stock_ok = 1'b1;
  assign Sold_Out = '0;
`endif

  // State register
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (sell)        state_d = StDispense;
        else if (refund) state_d = StGiveCh;
      end
      StDispense: if (dcnt_q == '0) state_d = StIdle;
      StGiveCh:   if (Change <= CREDIT_W'(1)) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // Next values of registered outputs, credit and timers
  always_comb begin
    credit_d   = Credit;
    change_d   = Change;
    pulse_d    = 1'b0;
    dispense_d = Dispense;
    reject_d   = Coin_In && !coin_ok;
    timer_d    = TMR_W'(TIMEOUT_CYC);
    dcnt_d     = dcnt_q;
    unique case (state_q)
      StIdle: begin
        if (sell) begin
          credit_d   = Credit - price_sel;
          dispense_d = sel_onehot;
          dcnt_d     = DCNT_W'(DISPENSE_CYC - 1);
        end else if (refund) begin
          change_d = Credit;
          credit_d = '0;
          pulse_d  = 1'b1;
        end else if (coin_ok) begin
          credit_d = Credit + Coin_Amt;
        end else if (Credit != '0) begin
          // An ignored Select or rejected coin is not activity: keep counting down
          timer_d = timer_q - TMR_W'(1);
        end
      end
      StDispense: begin
        if (dcnt_q == '0) dispense_d = '0;
        else              dcnt_d     = dcnt_q - DCNT_W'(1);
      end
      StGiveCh: begin
        // Pulse is shown alongside each unit still owed (Change = N..1)
        if (Change != '0) change_d = Change - CREDIT_W'(1);
        pulse_d = (Change > CREDIT_W'(1));
      end
      default: ;
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      Credit       <= '0;
      Change       <= '0;
      Change_Pulse <= 1'b0;
      Dispense     <= '0;
      Busy         <= 1'b0;
      Coin_Reject  <= 1'b0;
      timer_q      <= TMR_W'(TIMEOUT_CYC);
      dcnt_q       <= '0;
    end else begin
      Credit       <= credit_d;
      Change       <= change_d;
      Change_Pulse <= pulse_d;
      Dispense     <= dispense_d;
      Busy         <= (state_d != StIdle);
      Coin_Reject  <= reject_d;
      timer_q      <= timer_d;
      dcnt_q       <= dcnt_d;
    end
  end

endmodule

// File: tb/tb_param_vending_machine.sv
// Self-checking bench for param_vending_machine (default parameters).
// Reference model is transaction level: a sale or refund schedules a queue of future
// output frames; idle behaviour is derived from credit and elapsed idle cycles.
module tb_param_vending_machine;

  localparam int N    = 4;
  localparam int CW   = 6;
  localparam int MAXC = 32;
  localparam int DC   = 3;
  localparam int TO   = 4;
  localparam int SINIT = 3;

  logic          Clock = 1'b0;
  logic          nReset = 1'b0;
  logic          Coin_In = 1'b0;
  logic [CW-1:0] Coin_Amt = '0;
  logic          Req_Change = 1'b0;
  logic [N-1:0]  Select = '0;
  logic [CW-1:0] Credit, Change;
  logic          Change_Pulse, Busy, Coin_Reject;
  logic [N-1:0]  Dispense, Sold_Out;

  param_vending_machine dut (
    .Clock(Clock), .nReset(nReset), .Coin_In(Coin_In), .Coin_Amt(Coin_Amt),
    .Req_Change(Req_Change), .Select(Select), .Credit(Credit), .Change(Change),
    .Change_Pulse(Change_Pulse), .Dispense(Dispense), .Busy(Busy),
    .Coin_Reject(Coin_Reject), .Sold_Out(Sold_Out)
  );

  always #5 Clock = ~Clock;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [22:0] obs;
  assign obs = {Credit, Change, Change_Pulse, Dispense, Busy, Coin_Reject, Sold_Out};

  int checks = 0;
  int fails  = 0;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [3:0] disp;
    logic [5:0] chg;
    logic       pulse;
  } frame_t;

  int     price [N] = '{2, 3, 3, 4};
  frame_t fq[$];
  int     m_credit, m_idle;
  int     m_stock [N];
  bit     m_busy;
  logic [22:0] exp_v;

  function automatic logic [3:0] sold_vec();
    logic [3:0] s = '0;
`ifdef VEND_STOCK_EN
    for (int i = 0; i < N; i++) s[i] = (m_stock[i] == 0);
`endif
    return s;
  endfunction

  function automatic void model_reset();
    m_credit = 0; m_idle = 0; m_busy = 0;
    fq.delete();
    for (int i = 0; i < N; i++) m_stock[i] = SINIT;
    exp_v = {6'd0, 6'd0, 1'b0, 4'd0, 1'b0, 1'b0, sold_vec()};
  endfunction

  function automatic void model_step(bit coin, int amt, bit req, logic [3:0] sel);
    frame_t f = '0;
    bit rej = 0;
    int w = -1;
    if (m_busy) begin
      rej = coin;
      if (fq.size() > 0) f = fq.pop_front();
      else begin m_busy = 0; m_idle = 0; end
    end else begin
      for (int i = N - 1; i >= 0; i--) if (sel[i]) w = i;
      if (w >= 0 && m_credit >= price[w] && m_stock[w] > 0) begin
        m_credit -= price[w];
`ifdef VEND_STOCK_EN
        m_stock[w]--;
`endif
        for (int k = 0; k < DC; k++) begin
          frame_t d = '0;
          d.disp = 4'(1 << w);
          fq.push_back(d);
        end
        f = fq.pop_front(); m_busy = 1; rej = coin;
      end else if ((req || m_idle >= TO) && m_credit != 0) begin
        for (int k = m_credit; k >= 1; k--) begin
          frame_t c = '0;
          c.chg = 6'(k); c.pulse = 1'b1;
          fq.push_back(c);
        end
        m_credit = 0; f = fq.pop_front(); m_busy = 1; rej = coin;
      end else if (coin && m_credit + amt <= MAXC) begin
        m_credit += amt; m_idle = 0;
      end else begin
        rej = coin;
        if (m_credit == 0) m_idle = 0; else m_idle++;
      end
    end
    exp_v = {6'(m_credit), f.chg, f.pulse, f.disp, m_busy, rej, sold_vec()};
  endfunction

  // One clock cycle of stimulus; the model advances alongside the DUT
  task automatic cycle(input bit coin, input int amt, input bit req, input logic [3:0] sel);
    Coin_In = coin; Coin_Amt = CW'(amt); Req_Change = req; Select = sel;
    @(posedge Clock); #1;
    model_step(coin, amt, req, sel);
    Coin_In = 0; Coin_Amt = '0; Req_Change = 0; Select = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    nReset = 0;
    repeat (2) @(posedge Clock);
    #1;
    model_reset();
    checks++;
    if (obs !== exp_v) begin
      fails++; $display("FAIL reset_model: got %h want %h", obs, exp_v);
    end
    checks++;
    if (obs !== 23'd0) begin
      fails++; $display("FAIL reset_zero: got %h want 0", obs);
    end
    nReset = 1;
  endtask

  task automatic test_sale();
    int ndisp = 0;
    cycle(1, 2, 0, 4'b0000);
    cycle(1, 2, 0, 4'b0000);
    checks++;
    if (Credit !== 6'd4) begin fails++; $display("FAIL sale_credit4: got %0d want 4", Credit); end
    cycle(0, 0, 0, 4'b0001);
    checks++;
    if (Credit !== 6'd2) begin fails++; $display("FAIL sale_credit2: got %0d want 2", Credit); end
    if (Dispense == 4'b0001 && Busy) ndisp++;
    for (int c = 0; c < 5; c++) begin
      cycle(0, 0, 0, 4'b0000);
      checks++;
      if (obs !== exp_v) begin
        fails++; $display("FAIL sale_cycle%0d: got %h want %h", c, obs, exp_v);
      end
      if (Dispense == 4'b0001 && Busy) ndisp++;
    end
    checks++;
    if (ndisp != 3) begin fails++; $display("FAIL sale_disp_len: got %0d want 3", ndisp); end
  endtask

  task automatic test_refund();
    int npulse = 0;
    cycle(1, 3, 0, 4'b0000);
    checks++;
    if (Credit !== 6'd5) begin fails++; $display("FAIL refund_credit5: got %0d want 5", Credit); end
    cycle(0, 0, 1, 4'b0000);
    checks++;
    if (Change !== 6'd5 || Credit !== 6'd0) begin
      fails++; $display("FAIL refund_start: got chg %0d cr %0d want 5 0", Change, Credit);
    end
    if (Change_Pulse) npulse++;
    for (int c = 0; c < 7; c++) begin
      cycle(0, 0, 0, 4'b0000);
      checks++;
      if (obs !== exp_v) begin
        fails++; $display("FAIL refund_cycle%0d: got %h want %h", c, obs, exp_v);
      end
      if (Change_Pulse) npulse++;
    end
    checks++;
    if (npulse != 5 || Change !== 6'd0 || Busy !== 1'b0) begin
      fails++; $display("FAIL refund_total: got pulses %0d chg %0d want 5 0", npulse, Change);
    end
  endtask

  task automatic test_reject();
    for (int c = 0; c < 3; c++) cycle(1, 10, 0, 4'b0000);
    cycle(1, 5, 0, 4'b0000);
    checks++;
    if (Coin_Reject !== 1'b1 || Credit !== 6'd30) begin
      fails++; $display("FAIL reject_ceiling: got rej %b cr %0d want 1 30", Coin_Reject, Credit);
    end
    cycle(0, 0, 0, 4'b0000);
    checks++;
    if (obs !== exp_v || Coin_Reject !== 1'b0) begin
      fails++; $display("FAIL reject_one_cycle: got %h want %h", obs, exp_v);
    end
    cycle(0, 0, 0, 4'b0001);
    cycle(1, 1, 0, 4'b0000);
    checks++;
    if (Coin_Reject !== 1'b1 || Credit !== 6'd28 || Busy !== 1'b1) begin
      fails++; $display("FAIL reject_busy: got rej %b cr %0d want 1 28", Coin_Reject, Credit);
    end
    for (int c = 0; c < 40; c++) begin
      cycle(0, 0, (c == 3), 4'b0000);
      checks++;
      if (obs !== exp_v) begin
        fails++; $display("FAIL reject_drain%0d: got %h want %h", c, obs, exp_v);
      end
    end
  endtask

  task automatic test_timeout();
    int first = -1;
    int nbusy = 0;
    cycle(1, 3, 0, 4'b0000);
    for (int c = 1; c <= 12; c++) begin
      cycle(0, 0, 0, 4'b0000);
      checks++;
      if (obs !== exp_v) begin
        fails++; $display("FAIL timeout_cycle%0d: got %h want %h", c, obs, exp_v);
      end
      if (Busy && first < 0) first = c;
    end
    checks++;
    if (first != TO + 1) begin
      fails++; $display("FAIL timeout_start: got cycle %0d want %0d", first, TO + 1);
    end
    for (int c = 0; c < 10; c++) begin
      cycle(0, 0, 0, 4'b0000);
      if (Busy) nbusy++;
    end
    checks++;
    if (nbusy != 0) begin fails++; $display("FAIL timeout_zero_credit: got %0d busy want 0", nbusy); end
  endtask

  task automatic test_stock();
    cycle(1, 12, 0, 4'b0000);
    for (int s = 0; s < 3; s++) begin
      cycle(0, 0, 0, 4'b0010);
      for (int c = 0; c < DC; c++) cycle(0, 0, 0, 4'b0000);
      checks++;
      if (obs !== exp_v) begin
        fails++; $display("FAIL stock_sale%0d: got %h want %h", s, obs, exp_v);
      end
    end
    cycle(0, 0, 0, 4'b0010);
    checks++;
    if (obs !== exp_v) begin fails++; $display("FAIL stock_fourth: got %h want %h", obs, exp_v); end
`ifdef VEND_STOCK_EN
    checks++;
    if (Sold_Out[1] !== 1'b1 || Busy !== 1'b0 || Credit !== 6'd3) begin
      fails++; $display("FAIL stock_soldout: got so %b busy %b cr %0d want 1 0 3",
                        Sold_Out[1], Busy, Credit);
    end
`endif
    for (int c = 0; c < DC; c++) cycle(0, 0, 0, 4'b0000);
    cycle(0, 0, 1, 4'b0000);
    cycle(0, 0, 0, 4'b0000);
    // Asynchronous reset in the middle of the refund
    #2 nReset = 0;
    #1;
    model_reset();
    checks++;
    if (obs !== 23'd0 || obs !== exp_v) begin
      fails++; $display("FAIL stock_mid_reset: got %h want 0", obs);
    end
    @(posedge Clock); #1;
    nReset = 1;
    cycle(1, 3, 0, 4'b0000);
    cycle(0, 0, 0, 4'b0010);
    checks++;
    if (obs !== exp_v || Busy !== 1'b1 || Dispense !== 4'b0010) begin
      fails++; $display("FAIL stock_restored: got %h want %h", obs, exp_v);
    end
    for (int c = 0; c < DC; c++) cycle(0, 0, 0, 4'b0000);
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      bit coin = ($urandom_range(0, 2) == 0);
      int amt = $urandom_range(0, 12);
      bit req = ($urandom_range(0, 19) == 0);
      logic [3:0] sel = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
      cycle(coin, amt, req, sel);
      checks++;
      if (obs !== exp_v) begin
        fails++; $display("FAIL random_cycle%0d: got %h want %h", c, obs, exp_v);
      end
      if ($urandom_range(0, 399) == 0) begin
        #2 nReset = 0;
        #1;
        model_reset();
        checks++;
        if (obs !== exp_v) begin
          fails++; $display("FAIL random_reset%0d: got %h want %h", c, obs, exp_v);
        end
        @(posedge Clock); #1;
        nReset = 1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_sale();
    test_refund();
    test_reject();
    test_timeout();
    test_stock();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
